// File: rtl/alu_regfile_pkg.sv
`default_nettype none
// ============================================================================
// alu_regfile_pkg : widths, ALU group and opcode encodings for alu_regfile.
// Config macro ZERO_REG_EN : register 0 hardwired to zero.  Rev 1.0
// ============================================================================
package alu_regfile_pkg;

   localparam int DW   = 16;
   localparam int NREG = 16;
   localparam int AW   = 4;

`ifdef ZERO_REG_EN
   localparam bit ZERO_REG = 1'b1;
`else
   localparam bit ZERO_REG = 1'b0;
`endif

   localparam logic GRP_ARITH = 1'b0;
   localparam logic GRP_LOGIC = 1'b1;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_INC  = 3'd2;
   localparam logic [2:0] OP_DEC  = 3'd3;
   localparam logic [2:0] OP_NEG  = 3'd4;
   localparam logic [2:0] OP_CMP  = 3'd5;
   localparam logic [2:0] OP_ADDH = 3'd6;
   localparam logic [2:0] OP_PASS = 3'd7;

   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_XOR  = 3'd2;
   localparam logic [2:0] OP_NOT  = 3'd3;
   localparam logic [2:0] OP_SHL  = 3'd4;
   localparam logic [2:0] OP_SHR  = 3'd5;
   localparam logic [2:0] OP_SAR  = 3'd6;
   localparam logic [2:0] OP_ROL  = 3'd7;

endpackage
`default_nettype wire

// File: rtl/alu_regfile_if.sv
`default_nettype none
// ============================================================================
// alu_regfile_if : decoder-facing bus of the register file / ALU datapath.
// Rev 1.0
// ============================================================================
interface alu_regfile_if;
   import alu_regfile_pkg::*;

   logic          wr1_en;
   logic [AW-1:0] wr1_sel;
   logic          wr1_src;
   logic [DW-1:0] wr1_ext;
   logic          wr2_en;
   logic [AW-1:0] wr2_sel;
   logic [DW-1:0] wr2_data;
   logic [AW-1:0] rd1_sel;
   logic [DW-1:0] rd1_data;
   logic [AW-1:0] rd2_sel;
   logic [DW-1:0] rd2_data;
   logic          alu_select;
   logic [2:0]    alu_opcode;
   logic [DW-1:0] alu_result;
   logic          alu_cf;
   logic          alu_of;

   modport master (
      output wr1_en, wr1_sel, wr1_src, wr1_ext,
      output wr2_en, wr2_sel, wr2_data,
      output rd1_sel, rd2_sel, alu_select, alu_opcode,
      input  rd1_data, rd2_data, alu_result, alu_cf, alu_of
   );

   modport slave (
      input  wr1_en, wr1_sel, wr1_src, wr1_ext,
      input  wr2_en, wr2_sel, wr2_data,
      input  rd1_sel, rd2_sel, alu_select, alu_opcode,
      output rd1_data, rd2_data, alu_result, alu_cf, alu_of
   );

endinterface
`default_nettype wire

// File: rtl/alu_regfile_alu_unit.sv
`default_nettype none
// ============================================================================
// alu_unit : combinational 16-bit ALU, arithmetic and logic/shift groups.
// Rev 1.0
// ============================================================================
module alu_unit
   import alu_regfile_pkg::*;
(
   input  logic          select,
   input  logic [2:0]    opcode,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [DW-1:0] result,
   output logic          cf,
   output logic          of
);

   logic [3:0]           amt;
   logic [DW:0]          shl_ext;
   logic [DW:0]          shr_ext;
   logic signed [DW:0]   sar_ext;
   logic [DW-1:0]        rol;
   logic [DW-1:0]        x;
   logic [DW-1:0]        y;
   logic                 is_sub;
   logic [DW:0]          wide;

   // Shifters carry one extra bit so the last bit shifted out lands in it.
   assign amt     = b[3:0];
   assign shl_ext = {1'b0, a} << amt;
   assign shr_ext = {a, 1'b0} >> amt;
   assign sar_ext = $signed({a, 1'b0}) >>> amt;
   assign rol     = (a << amt) | (a >> (5'd16 - {1'b0, amt}));

   always_comb begin
      x      = a;
      y      = b;
      is_sub = 1'b0;
      wide   = '0;
      result = '0;
      cf     = 1'b0;
      of     = 1'b0;
      if (select == GRP_ARITH) begin
         // Every arithmetic op is x +/- y; PASS is a + 0, which leaves both flags clear.
         case (opcode)
            OP_ADD:          ;
            OP_SUB, OP_CMP:  is_sub = 1'b1;
            OP_INC:          y = DW'(1);
            OP_DEC:          begin y = DW'(1); is_sub = 1'b1; end
            OP_NEG:          begin x = '0; y = a; is_sub = 1'b1; end
            OP_ADDH:         y = b >> 8;
            default:         y = '0;
         endcase
         wide   = is_sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
         result = wide[DW-1:0];
         cf     = wide[DW];
         of     = is_sub ? ((x[DW-1] != y[DW-1]) && (result[DW-1] != x[DW-1]))
                         : ((x[DW-1] == y[DW-1]) && (result[DW-1] != x[DW-1]));
      end else begin
         case (opcode)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~a;
            OP_SHL:  begin result = shl_ext[DW-1:0]; cf = shl_ext[DW]; end
            OP_SHR:  begin result = shr_ext[DW:1];   cf = shr_ext[0];  end
            OP_SAR:  begin result = sar_ext[DW:1];   cf = sar_ext[0];  end
            default: begin result = rol;             cf = (amt != 4'd0) && rol[0]; end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
// alu_regfile : 16x16 register file (2W/2R) feeding a combinational ALU.
// Config macro ZERO_REG_EN : register 0 reads zero, writes to it dropped. Rev 1.0
// ============================================================================
module alu_regfile
   import alu_regfile_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   alu_regfile_if.slave bus
);

   logic [NREG-1:0][DW-1:0] regs;
   logic [DW-1:0]           wr1_data;
   logic                    wr1_ok;
   logic                    wr2_ok;

   assign wr1_data = bus.wr1_src ? bus.wr1_ext : bus.alu_result;
   assign wr1_ok   = bus.wr1_en && !(ZERO_REG && (bus.wr1_sel == '0));
   assign wr2_ok   = bus.wr2_en && !(ZERO_REG && (bus.wr2_sel == '0));

   // Port 1 is assigned last so it wins a same-index collision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs <= '0;
      end else begin
         if (wr2_ok) regs[bus.wr2_sel] <= bus.wr2_data;
         if (wr1_ok) regs[bus.wr1_sel] <= wr1_data;
      end
   end

   assign bus.rd1_data = regs[bus.rd1_sel];
   assign bus.rd2_data = regs[bus.rd2_sel];

   alu_unit u_alu (
      .select (bus.alu_select),
      .opcode (bus.alu_opcode),
      .a      (bus.rd1_data),
      .b      (bus.rd2_data),
      .result (bus.alu_result),
      .cf     (bus.alu_cf),
      .of     (bus.alu_of)
   );

endmodule
`default_nettype wire

// File: tb/tb_alu_regfile.sv
`default_nettype none
// ============================================================================
// tb_alu_regfile : directed vector table plus register-file corner sequences.
// Rev 1.0
// ============================================================================
module tb_alu_regfile;
   import alu_regfile_pkg::*;

   typedef struct packed {
      logic        sel;
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic        cf;
      logic        of;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_fail;
   vec_t vq[$];

   alu_regfile_if bus ();

   alu_regfile dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      bus.wr1_en = 1'b0;
      bus.wr2_en = 1'b0;
   endtask

   task automatic write2(input logic [3:0] s1, input logic [15:0] d1,
                         input logic [3:0] s2, input logic [15:0] d2);
      bus.wr1_en  = 1'b1; bus.wr1_sel = s1; bus.wr1_src = 1'b1; bus.wr1_ext = d1;
      bus.wr2_en  = 1'b1; bus.wr2_sel = s2; bus.wr2_data = d2;
      tick();
      idle();
   endtask

   initial begin
      n_vec  = 0;
      n_fail = 0;

      vq.push_back('{GRP_ARITH, OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0});
      vq.push_back('{GRP_ARITH, OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1});
      vq.push_back('{GRP_ARITH, OP_SUB,  16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0});
      vq.push_back('{GRP_ARITH, OP_ADD,  16'h000F, 16'h001E, 16'h002D, 1'b0, 1'b0});
      vq.push_back('{GRP_ARITH, OP_SUB,  16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0});
      vq.push_back('{GRP_ARITH, OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1});
      vq.push_back('{GRP_ARITH, OP_INC,  16'h7FFF, 16'h1234, 16'h8000, 1'b0, 1'b1});
      vq.push_back('{GRP_ARITH, OP_INC,  16'hFFFF, 16'h1234, 16'h0000, 1'b1, 1'b0});
      vq.push_back('{GRP_ARITH, OP_DEC,  16'h0000, 16'h1234, 16'hFFFF, 1'b1, 1'b0});
      vq.push_back('{GRP_ARITH, OP_DEC,  16'h8000, 16'h1234, 16'h7FFF, 1'b0, 1'b1});
      vq.push_back('{GRP_ARITH, OP_NEG,  16'h0001, 16'h1234, 16'hFFFF, 1'b1, 1'b0});
      vq.push_back('{GRP_ARITH, OP_NEG,  16'h8000, 16'h1234, 16'h8000, 1'b1, 1'b1});
      vq.push_back('{GRP_ARITH, OP_NEG,  16'h0000, 16'h1234, 16'h0000, 1'b0, 1'b0});
      vq.push_back('{GRP_ARITH, OP_CMP,  16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0});
      vq.push_back('{GRP_ARITH, OP_ADDH, 16'h00F0, 16'h1234, 16'h0102, 1'b0, 1'b0});
      vq.push_back('{GRP_ARITH, OP_ADDH, 16'hFFFF, 16'h0100, 16'h0000, 1'b1, 1'b0});
      vq.push_back('{GRP_ARITH, OP_PASS, 16'h8001, 16'hFFFF, 16'h8001, 1'b0, 1'b0});
      vq.push_back('{GRP_LOGIC, OP_AND,  16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0});
      vq.push_back('{GRP_LOGIC, OP_OR,   16'hF0F0, 16'h3C3C, 16'hFCFC, 1'b0, 1'b0});
      vq.push_back('{GRP_LOGIC, OP_XOR,  16'hF0F0, 16'h3C3C, 16'hCCCC, 1'b0, 1'b0});
      vq.push_back('{GRP_LOGIC, OP_NOT,  16'hF0F0, 16'h3C3C, 16'h0F0F, 1'b0, 1'b0});
      vq.push_back('{GRP_LOGIC, OP_SHL,  16'h8001, 16'h0001, 16'h0002, 1'b1, 1'b0});
      vq.push_back('{GRP_LOGIC, OP_SHL,  16'h8001, 16'h0010, 16'h8001, 1'b0, 1'b0});
      vq.push_back('{GRP_LOGIC, OP_SHR,  16'h8001, 16'h0001, 16'h4000, 1'b1, 1'b0});
      vq.push_back('{GRP_LOGIC, OP_SHR,  16'h0100, 16'h0009, 16'h0000, 1'b1, 1'b0});
      vq.push_back('{GRP_LOGIC, OP_SAR,  16'h8000, 16'h000F, 16'hFFFF, 1'b0, 1'b0});
      vq.push_back('{GRP_LOGIC, OP_SAR,  16'h4003, 16'h0001, 16'h2001, 1'b1, 1'b0});
      vq.push_back('{GRP_LOGIC, OP_ROL,  16'h8001, 16'h0004, 16'h0018, 1'b0, 1'b0});
      vq.push_back('{GRP_LOGIC, OP_ROL,  16'h8001, 16'h0001, 16'h0003, 1'b1, 1'b0});
      vq.push_back('{GRP_LOGIC, OP_ROL,  16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0});

      rst_n = 1'b0;
      idle();
      bus.wr1_sel = '0; bus.wr1_src = 1'b1; bus.wr1_ext = '0;
      bus.wr2_sel = '0; bus.wr2_data = '0;
      bus.rd1_sel = 4'd7; bus.rd2_sel = 4'd15;
      bus.alu_select = GRP_ARITH; bus.alu_opcode = OP_ADD;
      #12 rst_n = 1'b1;
      tick();
      check("reset_rd1", bus.rd1_data, 16'h0000);
      check("reset_rd2", bus.rd2_data, 16'h0000);

      // Mid-run asynchronous reset clears immediately, blocks writes, and stays clear.
      write2(4'd7, 16'h5A5A, 4'd15, 16'hA5A5);
      check("pre_reset_rd1", bus.rd1_data, 16'h5A5A);
      check("pre_reset_rd2", bus.rd2_data, 16'hA5A5);
      #3 rst_n = 1'b0;
      #1;
      check("async_reset_rd1", bus.rd1_data, 16'h0000);
      check("async_reset_rd2", bus.rd2_data, 16'h0000);
      bus.wr1_en = 1'b1; bus.wr1_sel = 4'd7; bus.wr1_ext = 16'h1111;
      tick();
      idle();
      check("write_in_reset", bus.rd1_data, 16'h0000);
      #2 rst_n = 1'b1;
      tick();
      tick();
      check("post_reset_rd1", bus.rd1_data, 16'h0000);
      check("post_reset_rd2", bus.rd2_data, 16'h0000);

      // Dual write, ADD, then store the ALU result through port 1.
      bus.rd1_sel = 4'd1; bus.rd2_sel = 4'd2;
      bus.alu_select = GRP_ARITH; bus.alu_opcode = OP_ADD;
      write2(4'd1, 16'd15, 4'd2, 16'd30);
      check("dual_rd1", bus.rd1_data, 16'd15);
      check("dual_rd2", bus.rd2_data, 16'd30);
      check("dual_add", bus.alu_result, 16'd45);
      bus.wr1_en = 1'b1; bus.wr1_sel = 4'd3; bus.wr1_src = 1'b0;
      tick();
      idle();
      bus.wr1_src = 1'b1;
      bus.rd1_sel = 4'd3;
      #1;
      check("alu_to_r3", bus.rd1_data, 16'd45);

      // Same-index collision: port 1 data must win.
      write2(4'd5, 16'h1111, 4'd5, 16'h2222);
      bus.rd1_sel = 4'd5;
      #1;
      check("collision_r5", bus.rd1_data, 16'h1111);

      // Register 0 behaviour depends on the build configuration.
      write2(4'd0, 16'hABCD, 4'd6, 16'h0606);
      bus.rd1_sel = 4'd0; bus.rd2_sel = 4'd6;
      #1;
`ifdef ZERO_REG_EN
      check("r0_port1", bus.rd1_data, 16'h0000);
`else
      check("r0_port1", bus.rd1_data, 16'hABCD);
`endif
      check("r6_port2", bus.rd2_data, 16'h0606);
      write2(4'd9, 16'h0909, 4'd0, 16'hABCD);
      #1;
`ifdef ZERO_REG_EN
      check("r0_port2", bus.rd1_data, 16'h0000);
`else
      check("r0_port2", bus.rd1_data, 16'hABCD);
`endif

      // Table: operand A in r1 via port 1, operand B in r2 via port 2.
      bus.rd1_sel = 4'd1; bus.rd2_sel = 4'd2;
      foreach (vq[i]) begin
         bus.alu_select = vq[i].sel;
         bus.alu_opcode = vq[i].op;
         write2(4'd1, vq[i].a, 4'd2, vq[i].b);
         check($sformatf("v%0d_rd1", i), bus.rd1_data, vq[i].a);
         check($sformatf("v%0d_result", i), bus.alu_result, vq[i].res);
         check($sformatf("v%0d_cf", i), {15'd0, bus.alu_cf}, {15'd0, vq[i].cf});
         check($sformatf("v%0d_of", i), {15'd0, bus.alu_of}, {15'd0, vq[i].of});
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
